// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared constants, fetch state encodings and helpers for the IF stage
package if_stage_pkg;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam int          STALL_W   = 6;

    typedef enum logic [1:0] {
        IF_LOOKUP = 2'd0,
        IF_WAIT   = 2'd1,
        IF_READY  = 2'd2
    } if_state_e;

    // Fetch addresses are always word aligned; low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped one-word-per-line instruction cache
module icache_dm #(
    parameter int LINES   = 64,
    parameter int INDEX_W = $clog2(LINES),
    parameter int TAG_W   = 30 - INDEX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_index,
    input  logic [TAG_W-1:0]   rd_tag,
    output logic               rd_hit,
    output logic [31:0]        rd_data,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [31:0]        wr_data
);

    logic [LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [TAG_W-1:0] tag_d  [LINES];
    logic [31:0]      data_q [LINES];
    logic [31:0]      data_d [LINES];

    // Combinational read port: hit needs a valid line with a matching tag.
    always_comb begin
        rd_hit  = valid_q[rd_index] && (tag_q[rd_index] == rd_tag);
        rd_data = data_q[rd_index];
    end

    // Next-state of the arrays: a single line is written per fill.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en) begin
            valid_d[wr_index] = 1'b1;
            tag_d[wr_index]   = wr_tag;
            data_d[wr_index]  = wr_data;
        end
    end

    // Valid bits are the only state that must clear on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data storage carry no reset; valid bits qualify them.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with PC, icache lookup and miss handling
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          ICACHE_LINES = 64,
    parameter int          INDEX_W      = $clog2(ICACHE_LINES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall_state,
    input  logic               ex_b_flag_i,
    input  logic [31:0]        ex_b_target_i,
    output logic [31:0]        if_pc,
    output logic [31:0]        if_inst,
    output logic               if_stall_req,
    output logic               mem_req,
    output logic [31:0]        mem_addr,
    input  logic               mem_ack,
    input  logic               mem_valid,
    input  logic [31:0]        mem_rdata
);

    localparam int TAG_W = 30 - INDEX_W;

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        discard_q, discard_d;
    logic [31:0] hold_q, hold_d;
    logic [29:0] req_word_q, req_word_d;   // word address of the outstanding request

    logic        hit;
    logic [31:0] hit_data;
    logic        fill_en;
    logic        inst_valid;
    logic        unused_bits;

    assign unused_bits = ^{stall_state[STALL_W-1:1], ex_b_target_i[1:0]};

    icache_dm #(
        .LINES   (ICACHE_LINES),
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_icache (
        .clk      (clk),
        .rst      (rst),
        .rd_index (pc_q[INDEX_W+1:2]),
        .rd_tag   (pc_q[31:INDEX_W+2]),
        .rd_hit   (hit),
        .rd_data  (hit_data),
        .wr_en    (fill_en),
        .wr_index (req_word_q[INDEX_W-1:0]),
        .wr_tag   (req_word_q[29:INDEX_W]),
        .wr_data  (mem_rdata)
    );

    // Fetch control: lookup/miss/fill sequencing, advance, then branch override.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        discard_d    = discard_q;
        hold_d       = hold_q;
        req_word_d   = req_word_q;
        inst_valid   = 1'b0;
        fill_en      = 1'b0;
        mem_req      = 1'b0;
        mem_addr     = pc_q;
        if_pc        = pc_q;
        if_inst      = ZERO_WORD;
        if_stall_req = 1'b1;

        case (state_q)
            IF_LOOKUP: begin
                if (hit) begin
                    inst_valid   = 1'b1;
                    if_inst      = hit_data;
                    if_stall_req = 1'b0;
                end else begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        req_word_d = pc_q[31:2];
                        state_d    = IF_WAIT;
                    end
                end
            end
            IF_WAIT: begin
                if (mem_valid) begin
                    // The returned word is correct for its address even if stale.
                    fill_en = 1'b1;
                    if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = IF_LOOKUP;
                    end else begin
                        hold_d  = mem_rdata;
                        state_d = IF_READY;
                    end
                end
            end
            IF_READY: begin
                inst_valid   = 1'b1;
                if_inst      = hold_q;
                if_stall_req = 1'b0;
            end
            default: begin
                state_d = IF_LOOKUP;
            end
        endcase

        if (inst_valid && !stall_state[0]) begin
            pc_d    = pc_q + 32'd4;
            state_d = IF_LOOKUP;
        end

        if (ex_b_flag_i) begin
            pc_d = word_align(ex_b_target_i);
            case (state_q)
                IF_LOOKUP: begin
                    if (!hit && mem_ack) begin
                        state_d   = IF_WAIT;
                        discard_d = 1'b1;
                    end else begin
                        state_d = IF_LOOKUP;
                    end
                end
                IF_WAIT: begin
                    if (mem_valid) begin
                        state_d   = IF_LOOKUP;
                        discard_d = 1'b0;
                    end else begin
                        state_d   = IF_WAIT;
                        discard_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IF_LOOKUP;
                end
            endcase
        end

        if (rst) begin
            fill_en      = 1'b0;
            mem_req      = 1'b0;
            if_pc        = RESET_PC;
            if_inst      = ZERO_WORD;
            if_stall_req = 1'b1;
        end
    end

    // Stage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IF_LOOKUP;
            pc_q       <= RESET_PC;
            discard_q  <= 1'b0;
            hold_q     <= ZERO_WORD;
            req_word_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            discard_q  <= discard_d;
            hold_q     <= hold_d;
            req_word_q <= req_word_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_state;
    logic        ex_b_flag_i;
    logic [31:0] ex_b_target_i;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_stall_req;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic        mem_valid;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall_state   (stall_state),
        .ex_b_flag_i   (ex_b_flag_i),
        .ex_b_target_i (ex_b_target_i),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .if_stall_req  (if_stall_req),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_valid     (mem_valid),
        .mem_rdata     (mem_rdata)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    typedef struct {
        logic [31:0] target;
        int          ack_dly;
        int          valid_dly;
        logic [31:0] exp_addr;
        bit          exp_hit;
    } vec_t;

    exp_t        sb_q[$];
    vec_t        vecs[7];
    int          checks   = 0;
    int          failures = 0;

    bit          agent_en;
    int          ack_dly, valid_dly, ack_cnt, vcnt;
    bit          ag_busy;
    logic [31:0] ag_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a << 8) | 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Memory controller model: acks after ack_dly cycles, returns data valid_dly+1 cycles later.
    task automatic settle();
        #1;
        if (agent_en) begin
            if (ag_busy) begin
                if (vcnt == valid_dly) begin
                    mem_valid = 1'b1;
                    mem_rdata = mem_word(ag_addr);
                    ag_busy   = 1'b0;
                end else begin
                    vcnt++;
                end
            end else if (mem_req) begin
                if (ack_cnt >= ack_dly) begin
                    mem_ack = 1'b1;
                    ag_addr = mem_addr;
                    ag_busy = 1'b1;
                    vcnt    = 0;
                    ack_cnt = 0;
                end else begin
                    ack_cnt++;
                end
            end else begin
                ack_cnt = 0;
            end
        end
    endtask

    // Monitor: every instruction taken by IF/ID is popped from the scoreboard.
    task automatic finish_cyc();
        exp_t e;
        #1;
        if (!rst && !if_stall_req && !ex_b_flag_i && !stall_state[0]) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual_pc=%h actual_inst=%h required=none", if_pc, if_inst);
            end else begin
                e = sb_q.pop_front();
                chk("sb_pc", if_pc, e.pc);
                chk("sb_inst", if_inst, e.inst);
            end
        end
        @(posedge clk);
        #1;
        mem_ack     = 1'b0;
        mem_valid   = 1'b0;
        ex_b_flag_i = 1'b0;
    endtask

    task automatic cycle();
        settle();
        finish_cyc();
    endtask

    task automatic branch_to(input logic [31:0] t);
        ex_b_flag_i   = 1'b1;
        ex_b_target_i = t;
        cycle();
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            cycle();
            n++;
        end
        chk(name, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    task automatic wait_ready(input string name, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            settle();
            ok = !if_stall_req;
            finish_cyc();
            if (ok) break;
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int          stall_cnt;
        bit          presented;
        bit          found;
        bit          acked;
        logic [31:0] nxt;

        vecs[0] = '{32'h1000_0024, 0, 0, 32'h1000_0024, 1'b0};
        vecs[1] = '{32'h1000_0027, 0, 0, 32'h1000_0024, 1'b1};
        vecs[2] = '{32'h2000_0058, 2, 1, 32'h2000_0058, 1'b0};
        vecs[3] = '{32'hFFFF_FFFC, 1, 3, 32'hFFFF_FFFC, 1'b0};
        vecs[4] = '{32'h2000_005B, 0, 0, 32'h2000_0058, 1'b1};
        vecs[5] = '{32'h0000_0008, 0, 0, 32'h0000_0008, 1'b1};
        vecs[6] = '{32'h3000_0058, 0, 1, 32'h3000_0058, 1'b0};

        rst           = 1'b1;
        stall_state   = 6'b000000;
        ex_b_flag_i   = 1'b0;
        ex_b_target_i = 32'h0;
        mem_ack       = 1'b0;
        mem_valid     = 1'b0;
        mem_rdata     = 32'h0;
        agent_en      = 1'b1;
        ack_dly       = 0;
        valid_dly     = 2;
        ack_cnt       = 0;
        vcnt          = 0;
        ag_busy       = 1'b0;
        ag_addr       = 32'h0;

        // Reset state
        @(posedge clk);
        #1;
        settle();
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_inst", if_inst, 32'h0);
        chk("rst_stall", 32'(if_stall_req), 32'd1);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        finish_cyc();
        cycle();
        rst = 1'b0;

        // Cold fetch of address 0
        sb_q.push_back('{32'h0, 32'h0000_0013});
        stall_cnt = 0;
        presented = 1'b0;
        for (int i = 0; i < 20; i++) begin
            settle();
            if (i == 0) begin
                chk("cold_mem_req", 32'(mem_req), 32'd1);
                chk("cold_mem_addr", mem_addr, 32'h0);
            end
            if (!if_stall_req) presented = 1'b1;
            else stall_cnt++;
            finish_cyc();
            if (presented) break;
        end
        chk("cold_latency", 32'(stall_cnt), 32'd4);
        chk("cold_drain", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        stall_state = 6'b000001;
        settle();
        chk("cold_next_pc", if_pc, 32'h4);
        finish_cyc();
        wait_ready("ready4", 12);

        // Hit path: refetch of 0 after a branch
        branch_to(32'h0);
        settle();
        chk("hit_no_req", 32'(mem_req), 32'd0);
        chk("hit_stall", 32'(if_stall_req), 32'd0);
        chk("hit_inst", if_inst, 32'h0000_0013);
        chk("hit_pc", if_pc, 32'h0);
        finish_cyc();

        // Pipeline stall holding the instruction at pc 8
        branch_to(32'h8);
        wait_ready("ready8", 12);
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("stall_pc", if_pc, 32'h8);
            chk("stall_inst", if_inst, mem_word(32'h8));
            chk("stall_valid", 32'(if_stall_req), 32'd0);
            finish_cyc();
        end
        sb_q.push_back('{32'h8, mem_word(32'h8)});
        stall_state = 6'b000000;
        cycle();
        stall_state = 6'b000001;
        settle();
        chk("stall_next_pc", if_pc, 32'hC);
        finish_cyc();
        chk("stall_drain", 32'(sb_q.size()), 32'd0);
        sb_q.delete();

        // Table-driven redirects: miss/hit, misaligned targets, wrap, tag conflict
        for (int k = 0; k < 7; k++) begin
            wait_ready("vec_pre_ready", 20);
            ack_dly   = vecs[k].ack_dly;
            valid_dly = vecs[k].valid_dly;
            branch_to(vecs[k].target);
            stall_state = 6'b000000;
            sb_q.push_back('{vecs[k].exp_addr, mem_word(vecs[k].exp_addr)});
            settle();
            chk("vec_mem_req", 32'(mem_req), 32'(!vecs[k].exp_hit));
            chk("vec_mem_addr", mem_addr, vecs[k].exp_addr);
            chk("vec_stall", 32'(if_stall_req), 32'(!vecs[k].exp_hit));
            finish_cyc();
            wait_drain("vec_drain", 20);
            stall_state = 6'b000001;
            nxt = vecs[k].exp_addr + 32'd4;
            settle();
            chk("vec_next_pc", if_pc, nxt);
            finish_cyc();
        end

        // Branch during WAIT: stale fill is cached but not presented
        wait_ready("bw_pre_ready", 20);
        ack_dly   = 0;
        valid_dly = 3;
        branch_to(32'h10);
        settle();
        chk("bw_mem_req", 32'(mem_req), 32'd1);
        chk("bw_mem_addr", mem_addr, 32'h10);
        finish_cyc();
        branch_to(32'h40);
        found     = 1'b0;
        presented = 1'b0;
        for (int i = 0; i < 20; i++) begin
            settle();
            if (mem_req) begin
                found = 1'b1;
                break;
            end
            if (!if_stall_req) presented = 1'b1;
            finish_cyc();
        end
        chk("bw_found_req", 32'(found), 32'd1);
        chk("bw_next_addr", mem_addr, 32'h40);
        chk("bw_not_presented", 32'(presented), 32'd0);
        finish_cyc();
        wait_ready("bw_ready40", 20);
        branch_to(32'h10);
        settle();
        chk("bw_refetch_no_req", 32'(mem_req), 32'd0);
        chk("bw_refetch_stall", 32'(if_stall_req), 32'd0);
        chk("bw_refetch_inst", if_inst, mem_word(32'h10));
        finish_cyc();

        // Branch and ack collide in LOOKUP
        agent_en = 1'b0;
        branch_to(32'h5000_0060);
        settle();
        chk("col_mem_req", 32'(mem_req), 32'd1);
        mem_ack       = 1'b1;
        ex_b_flag_i   = 1'b1;
        ex_b_target_i = 32'h0000_0081;
        finish_cyc();
        settle();
        chk("col_wait_no_req", 32'(mem_req), 32'd0);
        chk("col_wait_stall", 32'(if_stall_req), 32'd1);
        finish_cyc();
        cycle();
        mem_valid = 1'b1;
        mem_rdata = mem_word(32'h5000_0060);
        settle();
        chk("col_drop_stall", 32'(if_stall_req), 32'd1);
        finish_cyc();
        settle();
        chk("col_retry_req", 32'(mem_req), 32'd1);
        chk("col_retry_addr", mem_addr, 32'h80);
        chk("col_retry_stall", 32'(if_stall_req), 32'd1);
        finish_cyc();
        agent_en  = 1'b1;
        ag_busy   = 1'b0;
        ack_cnt   = 0;
        ack_dly   = 0;
        valid_dly = 1;
        sb_q.push_back('{32'h80, mem_word(32'h80)});
        stall_state = 6'b000000;
        wait_drain("col_drain", 20);
        stall_state = 6'b000001;

        // Reset while a request is outstanding
        wait_ready("rst_pre_ready", 20);
        valid_dly = 3;
        branch_to(32'h200);
        acked = 1'b0;
        for (int i = 0; i < 10; i++) begin
            settle();
            acked = mem_ack;
            finish_cyc();
            if (acked) break;
        end
        chk("mid_acked", 32'(acked), 32'd1);
        rst = 1'b1;
        settle();
        chk("mid_rst_pc", if_pc, 32'h0);
        chk("mid_rst_inst", if_inst, 32'h0);
        chk("mid_rst_stall", 32'(if_stall_req), 32'd1);
        chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
        finish_cyc();
        rst = 1'b0;
        settle();
        chk("mid_req", 32'(mem_req), 32'd1);
        chk("mid_addr", mem_addr, 32'h0);
        chk("mid_stall", 32'(if_stall_req), 32'd1);
        finish_cyc();
        sb_q.push_back('{32'h0, mem_word(32'h0)});
        stall_state = 6'b000000;
        wait_drain("mid_drain", 20);
        stall_state = 6'b000001;
        settle();
        chk("mid_line4_req", 32'(mem_req), 32'd1);
        chk("mid_line4_addr", mem_addr, 32'h4);
        finish_cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the PipyV 5-stage RISC-V pipeline. It is the producer side of the IF->ID boundary.
- Owns the PC, looks up a direct-mapped instruction cache, and on a miss fetches one 32-bit word from the memory controller. It then presents if_pc/if_inst to the IF/ID register.
- Raises a stall request while no instruction is available and redirects on an EX-resolved branch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ICACHE_LINES, 64, number of one-word cache lines; power of two, >= 2.
- INDEX_W, log2(ICACHE_LINES), index width; tag width = 30 - INDEX_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high (RstEnable)
- stall_state  in  StallBus(6)  bit0 = hold PC; other bits ignored here
- ex_b_flag_i  in  1  branch/jump taken, resolved in EX
- ex_b_target_i  in  32  redirect target
- if_pc  out  32  PC of presented instruction
- if_inst  out  32  instruction word; ZeroWord when none valid
- if_stall_req  out  1  high while no valid instruction is presented
- mem_req  out  1  fetch request to memory controller
- mem_addr  out  32  word-aligned fetch address
- mem_ack  in  1  controller accepted the request this cycle
- mem_valid  in  1  one-cycle pulse, read data returned
- mem_rdata  in  32  returned word, valid with mem_valid

Behaviour:
- Address rules
  - pc[1:0] is always 00; ex_b_target_i[1:0] is ignored and forced to 00.
  - index = pc[INDEX_W+1:2]; tag = pc[31:INDEX_W+2].
- Reset: pc = RESET_PC, all cache valid bits = 0, state = LOOKUP, mem_req = 0, discard = 0, hold register = 0. During reset if_pc = RESET_PC, if_inst = ZeroWord, if_stall_req = 1.
- LOOKUP state
  - Combinational cache lookup on pc.
  - Hit: if_inst = cached word, if_pc = pc, if_stall_req = 0.
  - Miss: if_inst = ZeroWord, if_stall_req = 1, mem_req = 1, mem_addr = pc. If mem_ack is high, go to WAIT.
  - mem_addr may change before ack (redirect); the controller samples only on mem_ack.
- WAIT state
  - mem_req = 0, if_stall_req = 1, if_inst = ZeroWord.
  - On mem_valid: write {tag, mem_rdata} to the line and set its valid bit. This happens even when discard = 1, since the data is correct for its address.
  - If discard = 0: capture mem_rdata into hold and go to READY.
  - If discard = 1: clear discard and go to LOOKUP.
- READY state: if_inst = hold, if_pc = pc, if_stall_req = 0.
- Advance
  - An instruction is valid in LOOKUP-hit or READY.
  - If it is valid and stall_state[0] = 0: pc <= pc + 4 (wraps modulo 2^32) and state <= LOOKUP.
  - If stall_state[0] = 1: pc and state hold; the same instruction stays presented.
- Branch priority: ex_b_flag_i beats advance and stall_state[0] in the same cycle; pc <= target.
  - LOOKUP: state stays LOOKUP; a request not yet acked is retargeted next cycle.
  - LOOKUP with mem_ack in the same cycle: go to WAIT with discard = 1.
  - WAIT: discard <= 1. If mem_valid arrives the same cycle, fill the cache and go to LOOKUP.
  - READY: go to LOOKUP.
- Single outstanding request only; a mem_valid seen outside WAIT is ignored.
- Outputs during the branch cycle are don't-care, because IF/ID squashes them.
- Latency: hit = 0 cycles after pc settles. Miss = one cycle after mem_valid (via READY).

Decomposition:
- Shared defines (existing defines.v): ZeroWord, RstEnable, StallBus, InstAddrBus, InstBus.
- Add to defines.v: IF_LOOKUP/IF_WAIT/IF_READY state encodings (2 bits).
- One sub-module: icache_dm. Holds tag/valid/data arrays, with a combinational read port (hit, data) and a synchronous write port. Its valid bits clear on rst.

Test Plan:
- Cold fetch: reset, mem_ack the next cycle, mem_valid + rdata=32'h00000013 three cycles later -> mem_addr=0, stall_req high until READY; if_pc=0, if_inst=32'h13; with stall_state[0]=0, pc becomes 4 the following cycle.
- Hit path: refetch addr 0 after a branch to 0 -> no mem_req; if_inst=32'h13 the same cycle, stall_req=0.
- Pipeline stall: READY at pc=8 with stall_state[0]=1 for 3 cycles -> if_pc=8 and if_inst stable for 3 cycles, then pc=12.
- Branch during WAIT: miss at 0x10 acked, ex_b_flag_i=1, target=0x40 -> when mem_valid arrives it fills line 0x10 but is not presented. Next mem_addr=0x40; a later fetch of 0x10 hits.
- Branch vs ack collision: mem_ack and ex_b_flag_i (target 0x81 -> 0x80) in the same cycle -> discard set; the first mem_valid is dropped, then mem_addr=0x80.
- Mid-op reset: rst asserted in WAIT -> pc=RESET_PC, all lines invalid; a late mem_valid is ignored; the next mem_req has addr 0.
